map_ram_writer: RTL and testbench

MAP_RAM_WRITER -- requirements
Module: map_ram_writer

---
 rtl/map_pkg.sv | 15 +
 rtl/map_addr_calc.sv | 20 ++
 rtl/map_ram_writer.sv | 124 ++++++++++++
 tb/tb_map_ram_writer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared map geometry, pixel width and writer FSM state encoding.
package map_pkg;

  localparam int MAP_W      = 160;
  localparam int MAP_H      = 90;
  localparam int MAP_DEPTH  = MAP_W * MAP_H;
  localparam int MAP_ADDR_W = $clog2(MAP_DEPTH);
  localparam int PIX_W      = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } map_state_e;

endpackage

// File: rtl/map_addr_calc.sv
// Row-major cell address y*WIDTH+x; the 160-wide map uses shift-add instead of a multiplier.
module map_addr_calc #(
  parameter int WIDTH  = map_pkg::MAP_W,
  parameter int ADDR_W = map_pkg::MAP_ADDR_W
) (
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  output logic [ADDR_W-1:0] addr
);

  generate
    if (WIDTH == 160) begin : g_shift_add
      // 160 = 128 + 32
      assign addr = ADDR_W'((32'(y) << 7) + (32'(y) << 5) + 32'(x));
    end else begin : g_generic
      assign addr = ADDR_W'(32'(y) * 32'(WIDTH) + 32'(x));
    end
  endgenerate

endmodule

// File: rtl/map_ram_writer.sv
// Map RAM write port: single-cell requests plus a whole-map fill engine that is
// compiled in only when MAP_WR_FILL_EN is defined.
module map_ram_writer #(
  parameter int WIDTH  = map_pkg::MAP_W,
  parameter int HEIGHT = map_pkg::MAP_H,
  parameter int PIX_W  = map_pkg::PIX_W
) (
  input  logic                            pixel_clk_in,
  input  logic                            rst_in,
  input  logic                            req_valid_in,
  output logic                            req_ready_out,
  input  logic [7:0]                      req_x_in,
  input  logic [6:0]                      req_y_in,
  input  logic [PIX_W-1:0]                req_color_in,
  input  logic                            fill_start_in,
  input  logic [PIX_W-1:0]                fill_color_in,
  output logic                            busy_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] ram_addr_out,
  output logic [PIX_W-1:0]                ram_data_out,
  output logic                            ram_we_out,
  output logic [15:0]                     drop_count_out
);
  import map_pkg::*;

  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(DEPTH);

  map_state_e        state;
  logic [ADDR_W-1:0] req_addr;
  logic              req_in_bounds;
  logic              req_accept;

  assign req_in_bounds = (int'(req_x_in) < WIDTH) && (int'(req_y_in) < HEIGHT);
  assign req_accept    = req_valid_in && req_ready_out;

  map_addr_calc #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .x    (req_x_in),
    .y    (req_y_in),
    .addr (req_addr)
  );

`ifdef MAP_WR_FILL_EN
  logic [ADDR_W-1:0] fill_cnt;
  logic [PIX_W-1:0]  fill_color;
  logic              fill_last;
`else
  logic unused_fill_inputs;
  assign unused_fill_inputs = ^{fill_start_in, fill_color_in};
  assign busy_out           = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset clears every register, including outputs.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= ST_IDLE;
      req_ready_out  <= 1'b0;
      ram_we_out     <= 1'b0;
      ram_addr_out   <= '0;
      ram_data_out   <= '0;
      drop_count_out <= '0;
`ifdef MAP_WR_FILL_EN
      busy_out       <= 1'b0;
      fill_cnt       <= '0;
      fill_color     <= '0;
      fill_last      <= 1'b0;
`endif
    end else begin
      ram_we_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_accept) begin
            if (req_in_bounds) begin
              ram_we_out   <= 1'b1;
              ram_addr_out <= req_addr;
              ram_data_out <= req_color_in;
            end else if (drop_count_out != 16'hFFFF) begin
              drop_count_out <= drop_count_out + 16'd1;
            end
          end
`ifdef MAP_WR_FILL_EN
          // A fill started alongside a request writes the request this edge,
          // then address 0 on the next.
          if (fill_start_in) begin
            state         <= ST_FILL;
            busy_out      <= 1'b1;
            req_ready_out <= 1'b0;
            fill_color    <= fill_color_in;
            fill_cnt      <= '0;
            fill_last     <= 1'b0;
          end else begin
            req_ready_out <= 1'b1;
          end
`else
          req_ready_out <= 1'b1;
`endif
        end
`ifdef MAP_WR_FILL_EN
        ST_FILL: begin
          if (fill_last) begin
            state         <= ST_IDLE;
            busy_out      <= 1'b0;
            req_ready_out <= 1'b1;
          end else begin
            ram_we_out   <= 1'b1;
            ram_addr_out <= fill_cnt;
            ram_data_out <= fill_color;
            fill_cnt     <= fill_cnt + 1'b1;
            fill_last    <= (fill_cnt == ADDR_W'(DEPTH - 1));
          end
        end
`endif
        default: begin
          state         <= ST_IDLE;
          req_ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_ram_writer.sv
// Self-checking bench for map_ram_writer; exercises the fill engine when MAP_WR_FILL_EN is defined.
module tb_map_ram_writer;

  localparam int W     = 160;
  localparam int H     = 90;
  localparam int DEPTH = W * H;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = 4;

  logic          pixel_clk_in = 1'b0;
  logic          rst_in       = 1'b0;
  logic          req_valid_in = 1'b0;
  logic          req_ready_out;
  logic [7:0]    req_x_in     = '0;
  logic [6:0]    req_y_in     = '0;
  logic [PW-1:0] req_color_in = '0;
  logic          fill_start_in = 1'b0;
  logic [PW-1:0] fill_color_in = '0;
  logic          busy_out;
  logic [AW-1:0] ram_addr_out;
  logic [PW-1:0] ram_data_out;
  logic          ram_we_out;
  logic [15:0]   drop_count_out;

  int errors = 0;
  int checks = 0;
  int exp_drops = 0;
  int exp_addr  = 0;

  always #5 pixel_clk_in = ~pixel_clk_in;

  map_ram_writer #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
    .pixel_clk_in   (pixel_clk_in),
    .rst_in         (rst_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_x_in       (req_x_in),
    .req_y_in       (req_y_in),
    .req_color_in   (req_color_in),
    .fill_start_in  (fill_start_in),
    .fill_color_in  (fill_color_in),
    .busy_out       (busy_out),
    .ram_addr_out   (ram_addr_out),
    .ram_data_out   (ram_data_out),
    .ram_we_out     (ram_we_out),
    .drop_count_out (drop_count_out)
  );

  function automatic bit in_bounds(input int x, input int y);
    return (x < W) && (y < H);
  endfunction

  function automatic int cell_addr(input int x, input int y);
    return y * W + x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk_in);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, req_ready_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_we"}, ram_we_out, 0);
    check({tag, "_addr"}, ram_addr_out, 0);
    check({tag, "_data"}, ram_data_out, 0);
    check({tag, "_drops"}, drop_count_out, 0);
  endtask

  // One handshake; expected write or drop comes from the cell-address rule.
  task automatic do_req(input int x, input int y, input int c, input string tag);
    check({tag, "_ready_pre"}, req_ready_out, 1);
    req_valid_in = 1'b1;
    req_x_in     = 8'(x);
    req_y_in     = 7'(y);
    req_color_in = PW'(c);
    step();
    req_valid_in = 1'b0;
    if (in_bounds(x, y)) begin
      exp_addr = cell_addr(x, y);
      check({tag, "_we"}, ram_we_out, 1);
      check({tag, "_addr"}, ram_addr_out, exp_addr);
      check({tag, "_data"}, ram_data_out, c);
    end else begin
      if (exp_drops < 65535) exp_drops++;
      check({tag, "_we"}, ram_we_out, 0);
    end
    check({tag, "_drops"}, drop_count_out, exp_drops);
  endtask

  initial begin
    int wr_count;
    int rx, ry, rc, gap;

    #3;
    check_all_zero("reset_hold");
    step();
    check_all_zero("reset_edge");
    rst_in = 1'b1;
    step();
    check("ready_after_release", req_ready_out, 1);
    check("busy_after_release", busy_out, 0);

    do_req(5, 2, 3, "req_5_2");
    step();
    check("idle_we_low", ram_we_out, 0);
    check("idle_addr_hold", ram_addr_out, 325);
    check("idle_data_hold", ram_data_out, 3);

    do_req(160, 0, 1, "req_oob_x");
    do_req(159, 89, 6, "req_last_cell");
    do_req(0, 90, 2, "req_oob_y");
    do_req(0, 0, 15, "req_first_cell");

    for (int n = 0; n < 40; n++) begin
      rx  = $urandom_range(0, 199);
      ry  = $urandom_range(0, 109);
      rc  = $urandom_range(0, 15);
      gap = $urandom_range(0, 2);
      do_req(rx, ry, rc, "rand_req");
      for (int g = 0; g < gap; g++) begin
        step();
        check("rand_gap_we", ram_we_out, 0);
        check("rand_gap_addr_hold", ram_addr_out, exp_addr);
      end
    end

`ifdef MAP_WR_FILL_EN
    fill_color_in = 4'd2;
    fill_start_in = 1'b1;
    step();
    fill_start_in = 1'b0;
    fill_color_in = 4'd5;
    check("fill_enter_busy", busy_out, 1);
    check("fill_enter_ready", req_ready_out, 0);
    check("fill_enter_we", ram_we_out, 0);

    for (int i = 0; i < DEPTH; i++) begin
      req_valid_in  = (i >= 200 && i < 210);
      req_x_in      = 8'd200;
      req_y_in      = 7'd0;
      fill_start_in = (i == 300);
      step();
      check("fill_addr", ram_addr_out, i);
      check("fill_we_ready_busy_data", {ram_we_out, req_ready_out, busy_out, ram_data_out},
            {1'b1, 1'b0, 1'b1, 4'd2});
    end
    req_valid_in  = 1'b0;
    fill_start_in = 1'b0;
    step();
    check("fill_done_busy", busy_out, 0);
    check("fill_done_ready", req_ready_out, 1);
    check("fill_done_we", ram_we_out, 0);
    check("fill_done_drops", drop_count_out, exp_drops);

    req_valid_in  = 1'b1;
    req_x_in      = 8'd1;
    req_y_in      = 7'd1;
    req_color_in  = 4'd7;
    fill_start_in = 1'b1;
    fill_color_in = 4'd4;
    step();
    req_valid_in  = 1'b0;
    fill_start_in = 1'b0;
    check("simul_req_we", ram_we_out, 1);
    check("simul_req_addr", ram_addr_out, 161);
    check("simul_req_data", ram_data_out, 7);
    check("simul_busy", busy_out, 1);
    check("simul_ready", req_ready_out, 0);
    for (int i = 0; i <= 5000; i++) begin
      step();
      check("fill2_addr", ram_addr_out, i);
      check("fill2_we_data", {ram_we_out, ram_data_out}, {1'b1, 4'd4});
    end

    #2;
    rst_in = 1'b0;
    #1;
    check_all_zero("reset_mid_fill");
    exp_drops = 0;
    step();
    check_all_zero("reset_mid_fill_edge");
    rst_in = 1'b1;
    step();
    check("mid_fill_release_ready", req_ready_out, 1);
    check("mid_fill_release_busy", busy_out, 0);
    wr_count = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ram_we_out === 1'b1 || busy_out === 1'b1) wr_count++;
    end
    check("no_fill_resume", wr_count, 0);
    do_req(10, 10, 9, "req_after_abort");
`else
    req_valid_in  = 1'b1;
    req_x_in      = 8'd3;
    req_y_in      = 7'd4;
    req_color_in  = 4'd1;
    fill_start_in = 1'b1;
    fill_color_in = 4'd9;
    step();
    req_valid_in  = 1'b0;
    fill_start_in = 1'b0;
    check("nofill_req_we", ram_we_out, 1);
    check("nofill_req_addr", ram_addr_out, 643);
    check("nofill_req_data", ram_data_out, 1);
    check("nofill_busy", busy_out, 0);
    check("nofill_ready", req_ready_out, 1);
    wr_count = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ram_we_out === 1'b1 || busy_out === 1'b1 || req_ready_out !== 1'b1) wr_count++;
    end
    check("nofill_stays_idle", wr_count, 0);
    do_req(0, 0, 5, "nofill_req_after");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
